deinterleaver: RTL and testbench

//   IEEE 802.11 OFDM block deinterleaver for the receive chain, sitting between the demapper and the Viterbi/depuncture path.

---
 rtl/deinterleaver.sv | 229 ++++++++++++++++++++++
 tb/tb_deinterleaver.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deinterleaver.sv
// -----------------------------------------------------------------------------
// deinterleaver
//   IEEE 802.11 OFDM block deinterleaver (receive chain, between the demapper
//   and the Viterbi/depuncture path). One OFDM symbol of hard coded bits
//   (48/96/192/288 bits) is collected into one of two byte banks. The inverse
//   of the transmit interleaver is then read back out of that bank while the
//   other bank fills, so the block sustains 1 byte/cycle on both sides.
//   Coded-bit index n lives in byte n/8, bit n%8 (LSB first), on both sides.
//
//   Handshake: a byte moves on a port at a rising aclk edge where tvalid and
//   tready are both high. A source holds tdata/tuser/tlast stable while
//   tvalid is high and tready is low, and never drops tvalid before the
//   transfer completes.
//
// Ports
//   aclk, aresetn        clock; synchronous active-low reset
//   s_axis_tdata  [7:0]  interleaved coded bits
//   s_axis_tuser  [3:0]  rate code, sampled on the first byte of a symbol
//   s_axis_tvalid/tready input handshake (tready = selected bank not full)
//   m_axis_tdata  [7:0]  deinterleaved coded bits
//   m_axis_tuser  [3:0]  rate code of the symbol being output
//   m_axis_tlast         high on the last byte of each symbol
//   m_axis_tvalid/tready output handshake
// -----------------------------------------------------------------------------
module deinterleaver (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] s_axis_tdata,
  input  logic [3:0] s_axis_tuser,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic [3:0] m_axis_tuser,
  output logic       m_axis_tlast,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready
);

  // Rate codes (SIGNAL field RATE bits)
  localparam logic [3:0] RATE_6M  = 4'b1011;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b1010;
  localparam logic [3:0] RATE_18M = 4'b1110;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1101;
  localparam logic [3:0] RATE_48M = 4'b1000;
  localparam logic [3:0] RATE_54M = 4'b1100;

  localparam int CBPS_BPSK  = 48;
  localparam int CBPS_QPSK  = 96;
  localparam int CBPS_QAM16 = 192;
  localparam int CBPS_QAM64 = 288;

  // Modulation class: 0 BPSK, 1 QPSK, 2 QAM16, 3 QAM64. Unknown codes -> BPSK.
  function automatic logic [1:0] rate_class(input logic [3:0] rate);
    case (rate)
      RATE_6M,  RATE_9M:  return 2'd0;
      RATE_12M, RATE_18M: return 2'd1;
      RATE_24M, RATE_36M: return 2'd2;
      RATE_48M, RATE_54M: return 2'd3;
      default:            return 2'd0;
    endcase
  endfunction

  function automatic logic [5:0] last_addr(input logic [1:0] cls);
    case (cls)
      2'd0:    return 6'd5;
      2'd1:    return 6'd11;
      2'd2:    return 6'd23;
      default: return 6'd35;
    endcase
  endfunction

  // Source bit j of output bit k for symbol size n and rotation unit s.
  // Evaluated only on constants, so it folds away into wiring.
  function automatic int perm_src(input int n, input int s, input int k);
    int i;
    i = (n / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  logic [7:0]   r_bank [2][36];
  logic [3:0]   r_rate [2];
  logic [1:0]   r_full;
  logic         r_wbank;
  logic         r_rbank;
  logic [5:0]   r_waddr;
  logic [5:0]   r_raddr;
  logic [7:0]   r_tdata;
  logic [3:0]   r_tuser;
  logic         r_tlast;
  logic         r_tvalid;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic         w_wr_hs;
  logic [3:0]   w_wr_rate;
  logic         w_wr_last;

  assign s_axis_tready = ~r_full[r_wbank];
  assign w_wr_hs       = s_axis_tvalid & ~r_full[r_wbank];
  // The symbol length is known from the first byte's tuser before it is stored.
  assign w_wr_rate     = (r_waddr == 6'd0) ? s_axis_tuser : r_rate[r_wbank];
  assign w_wr_last     = (r_waddr == last_addr(rate_class(w_wr_rate)));

  // ---------------------------------------------------------------------------
  // Read side: flatten the read bank, permute for every size, pick one byte
  // ---------------------------------------------------------------------------
  logic [287:0] w_src;
  logic [287:0] w_p_bpsk;
  logic [287:0] w_p_qpsk;
  logic [287:0] w_p_qam16;
  logic [287:0] w_p_qam64;
  logic [287:0] w_perm;
  logic [1:0]   w_rd_cls;
  logic         w_rd_last;
  logic         w_load;
  logic [7:0]   w_byte;

  for (genvar b = 0; b < 36; b++) begin : g_flat
    assign w_src[b*8 +: 8] = r_bank[r_rbank][b];
  end

  for (genvar k = 0; k < CBPS_BPSK; k++) begin : g_bpsk
    localparam int J = perm_src(CBPS_BPSK, 1, k);
    assign w_p_bpsk[k] = w_src[J];
  end
  assign w_p_bpsk[287:CBPS_BPSK] = '0;

  for (genvar k = 0; k < CBPS_QPSK; k++) begin : g_qpsk
    localparam int J = perm_src(CBPS_QPSK, 1, k);
    assign w_p_qpsk[k] = w_src[J];
  end
  assign w_p_qpsk[287:CBPS_QPSK] = '0;

  for (genvar k = 0; k < CBPS_QAM16; k++) begin : g_qam16
    localparam int J = perm_src(CBPS_QAM16, 2, k);
    assign w_p_qam16[k] = w_src[J];
  end
  assign w_p_qam16[287:CBPS_QAM16] = '0;

  for (genvar k = 0; k < CBPS_QAM64; k++) begin : g_qam64
    localparam int J = perm_src(CBPS_QAM64, 3, k);
    assign w_p_qam64[k] = w_src[J];
  end

  assign w_rd_cls  = rate_class(r_rate[r_rbank]);
  assign w_rd_last = (r_raddr == last_addr(w_rd_cls));
  // Load a new byte whenever the output register is empty or being drained.
  assign w_load    = r_full[r_rbank] & (~r_tvalid | m_axis_tready);

  always_comb begin
    w_perm = w_p_bpsk;
    case (w_rd_cls)
      2'd1:    w_perm = w_p_qpsk;
      2'd2:    w_perm = w_p_qam16;
      2'd3:    w_perm = w_p_qam64;
      default: w_perm = w_p_bpsk;
    endcase
  end

  assign w_byte = w_perm[{r_raddr, 3'b000} +: 8];

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (w_wr_hs) begin
      r_bank[r_wbank][r_waddr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rate[0] <= '0;
      r_rate[1] <= '0;
      r_full    <= '0;
      r_wbank   <= 1'b0;
      r_rbank   <= 1'b0;
      r_waddr   <= '0;
      r_raddr   <= '0;
      r_tdata   <= '0;
      r_tuser   <= '0;
      r_tlast   <= 1'b0;
      r_tvalid  <= 1'b0;
    end else begin
      if (w_wr_hs) begin
        if (r_waddr == 6'd0) begin
          r_rate[r_wbank] <= s_axis_tuser;
        end
        if (w_wr_last) begin
          r_full[r_wbank] <= 1'b1;
          r_wbank         <= ~r_wbank;
          r_waddr         <= '0;
        end else begin
          r_waddr <= r_waddr + 6'd1;
        end
      end

      if (w_load) begin
        r_tdata  <= w_byte;
        r_tuser  <= r_rate[r_rbank];
        r_tlast  <= w_rd_last;
        r_tvalid <= 1'b1;
        if (w_rd_last) begin
          // A completing write always targets the other bank here, so both
          // updates to r_full take effect in the same cycle.
          r_full[r_rbank] <= 1'b0;
          r_rbank         <= ~r_rbank;
          r_raddr         <= '0;
        end else begin
          r_raddr <= r_raddr + 6'd1;
        end
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;

endmodule

// File: tb/tb_deinterleaver.sv
// -----------------------------------------------------------------------------
// tb_deinterleaver
//   Self-checking bench for deinterleaver. A behavioural model rebuilds each
//   accepted symbol as a bit vector and applies the 802.11 deinterleave rule
//   directly; a negedge monitor compares every output transfer against the
//   resulting expected queues and checks output stability under backpressure.
// -----------------------------------------------------------------------------
module tb_deinterleaver;

  localparam logic [3:0] R6  = 4'b1011;
  localparam logic [3:0] R9  = 4'b1111;
  localparam logic [3:0] R12 = 4'b1010;
  localparam logic [3:0] R18 = 4'b1110;
  localparam logic [3:0] R24 = 4'b1001;
  localparam logic [3:0] R36 = 4'b1101;
  localparam logic [3:0] R48 = 4'b1000;
  localparam logic [3:0] R54 = 4'b1100;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] s_tdata = '0;
  logic [3:0] s_tuser = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic [3:0] m_tuser;
  logic       m_tlast;
  logic       m_tvalid;
  logic       m_tready = 1'b1;

  always #5 aclk = ~aclk;

  deinterleaver dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  int cyc = 0;
  always @(posedge aclk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic int nbytes(input logic [3:0] r);
    case (r)
      R12, R18: return 12;
      R24, R36: return 24;
      R48, R54: return 36;
      default:  return 6;
    endcase
  endfunction

  function automatic int sval(input logic [3:0] r);
    case (r)
      R24, R36: return 2;
      R48, R54: return 3;
      default:  return 1;
    endcase
  endfunction

  // Output bit k takes input bit j of the interleaved symbol.
  function automatic logic [287:0] model_out(input logic [3:0] r, input logic [287:0] v);
    logic [287:0] o;
    int n, s, i, j;
    n = nbytes(r) * 8;
    s = sval(r);
    o = '0;
    for (int k = 0; k < n; k++) begin
      i = (n / 16) * (k % 16) + k / 16;
      j = s * (i / s) + (i + n - (16 * i) / n) % s;
      o[k] = v[j];
    end
    return o;
  endfunction

  logic [7:0]   exp_q[$];
  logic [3:0]   exp_user_q[$];
  logic         exp_last_q[$];
  logic [12:0]  got_q[$];
  int           got_cyc_q[$];
  logic [287:0] part_vec = '0;
  int           part_cnt = 0;
  logic [3:0]   part_rate = '0;
  int           in_hs_cnt = 0;
  int           sym_done_cyc = 0;
  logic         stall_pend = 1'b0;
  logic [12:0]  stall_val = '0;

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard (negedge: transfers commit at the following posedge)
  // ---------------------------------------------------------------------------
  always @(negedge aclk) begin
    logic [287:0] o;
    if (!aresetn) begin
      exp_q.delete();
      exp_user_q.delete();
      exp_last_q.delete();
      part_cnt   = 0;
      part_vec   = '0;
      stall_pend = 1'b0;
    end else begin
      if (s_tvalid && s_tready) begin
        if (part_cnt == 0) part_rate = s_tuser;
        part_vec[part_cnt*8 +: 8] = s_tdata;
        part_cnt++;
        in_hs_cnt++;
        if (part_cnt == nbytes(part_rate)) begin
          o = model_out(part_rate, part_vec);
          for (int b = 0; b < nbytes(part_rate); b++) begin
            exp_q.push_back(o[b*8 +: 8]);
            exp_user_q.push_back(part_rate);
            exp_last_q.push_back(b == nbytes(part_rate) - 1);
          end
          part_cnt     = 0;
          part_vec     = '0;
          sym_done_cyc = cyc;
        end
      end

      if (m_tvalid) begin
        if (stall_pend) check("hold_stable", {m_tlast, m_tuser, m_tdata}, stall_val);
        if (m_tready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got 0x%0h expected no output", m_tdata);
          end else begin
            check("out_data", m_tdata, exp_q.pop_front());
            check("out_user", m_tuser, exp_user_q.pop_front());
            check("out_last", m_tlast, exp_last_q.pop_front());
          end
          got_q.push_back({m_tlast, m_tuser, m_tdata});
          got_cyc_q.push_back(cyc);
          stall_pend = 1'b0;
        end else begin
          stall_pend = 1'b1;
          stall_val  = {m_tlast, m_tuser, m_tdata};
        end
      end else if (stall_pend) begin
        check("valid_dropped", 1'b0, 1'b1);
        stall_pend = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output ready driver
  // ---------------------------------------------------------------------------
  logic ready_rand  = 1'b0;
  logic ready_force = 1'b1;

  always @(posedge aclk) begin
    #1;
    m_tready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // ---------------------------------------------------------------------------
  // Input driver tasks (all driving happens 1 time unit after posedge)
  // ---------------------------------------------------------------------------
  logic [7:0] sym_buf [36];
  int         in_stalls = 0;

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [3:0] u);
    logic hs;
    int   budget;
    budget   = 0;
    s_tdata  = d;
    s_tuser  = u;
    s_tvalid = 1'b1;
    forever begin
      hs = s_tready;
      @(posedge aclk); #1;
      if (hs) break;
      in_stalls++;
      budget++;
      if (budget > 2000) begin
        check("in_timeout", 1'b0, 1'b1);
        break;
      end
    end
  endtask

  // Non-first bytes carry junk tuser: only the first byte's rate counts.
  task automatic send_sym(input logic [3:0] r, input int nb, input int max_gap);
    int g;
    for (int b = 0; b < nb; b++) begin
      send_byte(sym_buf[b], (b == 0) ? r : 4'($urandom_range(0, 15)));
      if (max_gap > 0) begin
        g = $urandom_range(0, max_gap);
        if (g > 0) idle(g);
      end
    end
  endtask

  task automatic clear_buf();
    for (int b = 0; b < 36; b++) sym_buf[b] = 8'h00;
  endtask

  task automatic rand_buf();
    for (int b = 0; b < 36; b++) sym_buf[b] = 8'($urandom_range(0, 255));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    s_tvalid    = 1'b0;
    ready_rand  = 1'b0;
    ready_force = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge aclk); #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) begin @(posedge aclk); #1; end
  endtask

  task automatic start_log();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [287:0] pv;
  logic [287:0] po;
  logic [3:0]   rates [10];
  int           hs0;

  initial begin
    rates = '{R6, R9, R12, R18, R24, R36, R48, R54, 4'h0, 4'h7};

    // Reset
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tlast",  m_tlast,  1'b0);
    check("rst_tuser",  m_tuser,  4'h0);
    check("rst_tdata",  m_tdata,  8'h00);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("rst_s_tready", s_tready, 1'b1);

    // Pin the model with hand-derived permutations
    pv = '0; pv[3] = 1'b1;  po = model_out(R6, pv);
    check("pin_bpsk_bit3", po[47:0], 48'h0000_0000_0002);
    pv = '0; pv[1] = 1'b1;  po = model_out(R6, pv);
    check("pin_bpsk_bit1", po[47:0], 48'h0000_0001_0000);
    pv = '0; pv[13] = 1'b1; po = model_out(R24, pv);
    check("pin_qam16_lo", po[63:0], 64'h2);
    check("pin_qam16_hi", |po[191:64], 1'b0);
    pv = '0; pv[20] = 1'b1; po = model_out(R54, pv);
    check("pin_qam64_lo", po[63:0], 64'h2);
    check("pin_qam64_hi", |po[287:64], 1'b0);

    // BPSK: byte0 = 0x08 -> out byte0 = 0x02, tlast on byte 5, latency
    start_log();
    clear_buf(); sym_buf[0] = 8'h08;
    send_sym(R6, 6, 0);
    idle(1);
    drain(200);
    check("bpsk_a_count", got_q.size(), 6);
    if (got_q.size() == 6) begin
      check("bpsk_a_byte0", got_q[0][7:0], 8'h02);
      check("bpsk_a_byte1", got_q[1][7:0], 8'h00);
      check("bpsk_a_user",  got_q[0][11:8], R6);
      check("bpsk_a_last5", got_q[5][12], 1'b1);
      check("bpsk_a_last4", got_q[4][12], 1'b0);
      check("bpsk_a_latency", got_cyc_q[0] - sym_done_cyc, 2);
    end

    // BPSK: bit 1 -> bit 16
    start_log();
    clear_buf(); sym_buf[0] = 8'h02;
    send_sym(R9, 6, 0);
    drain(200);
    check("bpsk_b_count", got_q.size(), 6);
    if (got_q.size() == 6) begin
      check("bpsk_b_byte2", got_q[2][7:0], 8'h01);
      check("bpsk_b_byte0", got_q[0][7:0], 8'h00);
    end

    // QAM16: bit 13 -> bit 1
    start_log();
    clear_buf(); sym_buf[1] = 8'h20;
    send_sym(R36, 24, 0);
    drain(200);
    check("qam16_count", got_q.size(), 24);
    if (got_q.size() == 24) begin
      check("qam16_byte0", got_q[0][7:0], 8'h02);
      check("qam16_last23", got_q[23][12], 1'b1);
      check("qam16_last22", got_q[22][12], 1'b0);
      check("qam16_user", got_q[10][11:8], R36);
    end

    // QAM64: bit 20 -> bit 1
    start_log();
    clear_buf(); sym_buf[2] = 8'h10;
    send_sym(R54, 36, 0);
    drain(200);
    check("qam64_count", got_q.size(), 36);
    if (got_q.size() == 36) begin
      check("qam64_byte0", got_q[0][7:0], 8'h02);
      check("qam64_last35", got_q[35][12], 1'b1);
    end

    // Three back-to-back QAM64 symbols, no bubbles on either side
    start_log();
    in_stalls = 0;
    for (int n = 0; n < 3; n++) begin
      rand_buf();
      send_sym(R48, 36, 0);
    end
    check("b2b_in_stalls", in_stalls, 0);
    drain(400);
    check("b2b_count", got_q.size(), 108);
    if (got_q.size() == 108) check("b2b_out_span", got_cyc_q[107] - got_cyc_q[0], 107);

    // Backpressure: 3 QPSK symbols, output stalled for 100 cycles
    start_log();
    ready_force = 1'b0;
    @(posedge aclk); #1;
    hs0 = in_hs_cnt;
    fork
      begin
        for (int n = 0; n < 3; n++) begin
          rand_buf();
          send_sym(R12, 12, 0);
        end
        s_tvalid = 1'b0;
      end
      begin
        repeat (100) @(posedge aclk);
        #2;
        check("bp_accepted", in_hs_cnt - hs0, 24);
        check("bp_s_tready", s_tready, 1'b0);
        ready_force = 1'b1;
      end
    join
    drain(400);
    check("bp_count", got_q.size(), 36);

    // Random rates, data, valid gaps and ready
    start_log();
    ready_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rand_buf();
      send_sym(rates[$urandom_range(0, 9)], nbytes(rates[n % 10]) > 0 ? 36 : 36, 2);
    end
    drain(2000);

    // Reset mid-symbol
    start_log();
    ready_force = 1'b0;
    rand_buf();
    send_sym(R24, 24, 0);
    rand_buf();
    send_sym(R24, 10, 0);
    s_tvalid = 1'b0;
    idle(2);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("rst_mid_tvalid", m_tvalid, 1'b0);
    check("rst_mid_s_tready", s_tready, 1'b1);
    aresetn = 1'b1;
    ready_force = 1'b1;
    idle(3);
    check("rst_mid_quiet", got_q.size(), 0);
    start_log();
    clear_buf(); sym_buf[0] = 8'h08;
    send_sym(R6, 6, 0);
    drain(200);
    check("post_rst_count", got_q.size(), 6);
    if (got_q.size() == 6) check("post_rst_byte0", got_q[0][7:0], 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
